// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback controller driving an external 32-bit ALU.
// Owns pc, a 16x32 register file and the F1/F2 flags; minimum 4 cycles per instruction.
module alu_sequencer #(
    parameter int BRANCH_REG    = 8,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] start_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        alu_en,
    output logic [5:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [15:0] alu_value,
    output logic        alu_highlow,
    output logic        alu_f1,
    output logic        alu_f2,
    input  logic [31:0] alu_c,
    input  logic        alu_f3,
    output logic [31:0] pc,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic        retire
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam int         TW = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
    localparam logic [3:0] BR = 4'(BRANCH_REG);

    logic [2:0]    state;
    logic [31:0]   instr;
    logic [31:0]   rf [16];
    logic          f1, f2;
    logic [TW-1:0] tcnt;
    logic [31:0]   res_c;
    logic          res_f;

    logic [5:0]  op;
    logic [3:0]  rd, ra, rb;
    logic [15:0] imm;

    assign op  = instr[31:26];
    assign rd  = instr[25:22];
    assign ra  = instr[21:18];
    assign rb  = instr[17:14];
    assign imm = instr[15:0];

    // Handshake and status outputs decode straight from state so reset kills them at once.
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign alu_en    = (state == S_EXEC);
    assign alu_op    = op;
    assign alu_f1    = f1;
    assign alu_f2    = f2;
    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign halted    = (state == S_HALT);
    assign retire    = (state == S_WB);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pc          <= 32'd0;
            instr       <= 32'd0;
            f1          <= 1'b0;
            f2          <= 1'b0;
            fault       <= 1'b0;
            tcnt        <= '0;
            res_c       <= 32'd0;
            res_f       <= 1'b0;
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            alu_value   <= 16'd0;
            alu_highlow <= 1'b0;
            for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state <= S_FETCH;
                        pc    <= start_pc;
                        fault <= 1'b0;
                        tcnt  <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= S_DECODE;
                    end else if (tcnt == TW'(FETCH_TIMEOUT - 1)) begin
                        fault <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_DECODE: begin
                    alu_a       <= 32'd0;
                    alu_b       <= 32'd0;
                    alu_value   <= 16'd0;
                    alu_highlow <= 1'b0;
                    if (op <= 6'd3 || (op >= 6'd8 && op <= 6'd10)) begin
                        alu_a <= rf[ra];
                        alu_b <= rf[rb];
                    end else if (op == 6'd4 || op == 6'd7) begin
                        alu_a <= rf[ra];
                    end else if (op == 6'd5 || op == 6'd6) begin
                        alu_a       <= rf[rd];
                        alu_value   <= imm;
                        alu_highlow <= (op == 6'd6);
                    end
                    if (op == 6'd63) begin
                        state <= S_HALT;
                    end else if (op >= 6'd16) begin
                        fault <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_c <= alu_c;
                    res_f <= alu_f3;
                    state <= S_WB;
                end
                S_WB: begin
                    if (op <= 6'd7 && rd != 4'd0) rf[rd] <= res_c;
                    if (op >= 6'd8 && op <= 6'd13) begin
                        f2 <= f1;
                        f1 <= res_f;
                    end
                    if (op == 6'd14 || (op == 6'd15 && f1)) pc <= rf[BR];
                    else                                    pc <= pc + 32'd1;
                    tcnt  <= '0;
                    state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
